// File: rtl/pixel_filter3x3_if.sv
// Valid/ready pixel stream bundle for pixel_filter3x3: input stream (s_*) and result stream (m_*).
// The filter uses the slave view; the producer/consumer side uses the master view.
interface pixel_filter3x3_if #(
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0] s_pixel;
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] m_pixel;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (
    output s_pixel, s_valid, m_ready,
    input  s_ready, m_pixel, m_valid, m_last
  );

  modport slave (
    input  s_pixel, s_valid, m_ready,
    output s_ready, m_pixel, m_valid, m_last
  );
endinterface

// File: rtl/pixel_filter3x3.sv
// Streaming 3x3 neighbourhood filter (pass/invert/Laplacian/Gaussian) over one raster frame.
// Two line buffers feed a 3x3 window (stage 1); the filter result is registered at stage 2.
module pixel_filter3x3 #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int PIX_W      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  pixel_filter3x3_if.slave px,
  input  logic [1:0]       mode,
  output logic             frame_done
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT + 2);
  localparam int LW = PIX_W + 3;
  localparam int SW = PIX_W + 4;
  localparam logic [XW-1:0]    X_LAST  = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]    Y_LAST  = YW'(IMG_HEIGHT - 1);
  localparam logic [YW-1:0]    Y_FLUSH = YW'(IMG_HEIGHT + 1);
  localparam logic [PIX_W-1:0] MAX     = '1;

  typedef enum logic {STREAM, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [XW-1:0]    ix;
  logic [YW-1:0]    iy;
  logic [1:0]       mode_q;
  logic             en, s_rdy, accept, flush_stp, step, flush_end;
  logic [PIX_W-1:0] sample;
  logic             c_ok;
  logic [XW-1:0]    c_x;
  logic [YW-1:0]    c_y;

  logic [PIX_W-1:0] lb0 [IMG_WIDTH];
  logic [PIX_W-1:0] lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] win_p1 [3][3];
  logic             vld_p1;
  logic [XW-1:0]    cx_p1;
  logic [YW-1:0]    cy_p1;
  logic             border;
  logic [PIX_W-1:0] f_pix;

  function automatic logic [PIX_W-1:0] lap_clamp(
    input logic [PIX_W-1:0] c, n, s, e, w
  );
    logic signed [LW-1:0] v;
    v = $signed(LW'(c) << 2) - $signed(LW'(n)) - $signed(LW'(s))
      - $signed(LW'(e)) - $signed(LW'(w));
    if (v[LW-1])                   return '0;
    else if (v > $signed(LW'(MAX))) return MAX;
    else                           return v[PIX_W-1:0];
  endfunction

  function automatic logic [PIX_W-1:0] blur_trunc(
    input logic [PIX_W-1:0] c, n, s, e, w, k0, k1, k2, k3
  );
    logic [SW-1:0] sum;
    sum = SW'(k0) + SW'(k1) + SW'(k2) + SW'(k3)
        + ((SW'(n) + SW'(s) + SW'(e) + SW'(w)) << 1)
        + (SW'(c) << 2);
    return sum[SW-1:4];
  endfunction

  assign px.s_ready = s_rdy;

  always_comb begin
    state_d   = state_q;
    en        = !px.m_valid || px.m_ready;
    s_rdy     = (state_q == STREAM) && en;
    accept    = px.s_valid && s_rdy;
    flush_stp = (state_q == FLUSH) && en;
    step      = accept || flush_stp;
    sample    = flush_stp ? '0 : px.s_pixel;
    flush_end = flush_stp && (ix == '0) && (iy == Y_FLUSH);
    if (accept && (ix == X_LAST) && (iy == Y_LAST)) state_d = FLUSH;
    else if (flush_end)                             state_d = STREAM;
  end

  // Centre of the window after this step lags the newest sample by one line plus one pixel.
  always_comb begin
    c_ok = (iy >= YW'(2)) || ((iy == YW'(1)) && (ix != '0));
    if (ix != '0) begin
      c_x = ix - XW'(1);
      c_y = iy - YW'(1);
    end else begin
      c_x = X_LAST;
      c_y = iy - YW'(2);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= STREAM;
      ix      <= '0;
      iy      <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      if (accept && (ix == '0) && (iy == '0)) mode_q <= mode;
      if (step) begin
        if (flush_end) begin
          ix <= '0;
          iy <= '0;
        end else if (ix == X_LAST) begin
          ix <= '0;
          iy <= iy + YW'(1);
        end else begin
          ix <= ix + XW'(1);
        end
      end
    end
  end

  // Stage 1: line buffers and 3x3 window
  always_ff @(posedge clk) begin
    if (step) begin
      lb0[ix] <= lb1[ix];
      lb1[ix] <= sample;
      for (int r = 0; r < 3; r++) begin
        win_p1[r][0] <= win_p1[r][1];
        win_p1[r][1] <= win_p1[r][2];
      end
      win_p1[0][2] <= lb0[ix];
      win_p1[1][2] <= lb1[ix];
      win_p1[2][2] <= sample;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
      cx_p1  <= '0;
      cy_p1  <= '0;
    end else if (en) begin
      vld_p1 <= step && c_ok;
      if (step) begin
        cx_p1 <= c_x;
        cy_p1 <= c_y;
      end
    end
  end

  always_comb begin
    border = (cx_p1 == '0) || (cx_p1 == X_LAST) || (cy_p1 == '0) || (cy_p1 == Y_LAST);
    f_pix  = win_p1[1][1];
    case (mode_q)
      2'b01: f_pix = MAX - win_p1[1][1];
      2'b10: if (!border) f_pix = lap_clamp(win_p1[1][1], win_p1[0][1], win_p1[2][1],
                                             win_p1[1][2], win_p1[1][0]);
      2'b11: if (!border) f_pix = blur_trunc(win_p1[1][1], win_p1[0][1], win_p1[2][1],
                                              win_p1[1][2], win_p1[1][0], win_p1[0][0],
                                              win_p1[0][2], win_p1[2][0], win_p1[2][2]);
      default: f_pix = win_p1[1][1];
    endcase
  end

  // Stage 2: output register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      px.m_valid <= 1'b0;
      px.m_pixel <= '0;
      px.m_last  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (en) begin
        px.m_valid <= vld_p1;
        px.m_pixel <= f_pix;
        px.m_last  <= vld_p1 && (cx_p1 == X_LAST) && (cy_p1 == Y_LAST);
      end
      frame_done <= px.m_valid && px.m_ready && px.m_last;
    end
  end
endmodule

// File: tb/tb_pixel_filter3x3.sv
// Directed, table-driven bench for pixel_filter3x3 on a 4x3 frame with 8-bit pixels.
module tb_pixel_filter3x3;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = 8;
  localparam int NP = W * H;

  typedef struct packed {
    logic [1:0]  md;
    logic [1:0]  md_mid;
    logic [95:0] pix;
    logic [95:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       frame_done;
  bit         rnd_rdy = 1'b0;

  pixel_filter3x3_if #(.PIX_W(PW)) bus ();

  pixel_filter3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .px         (bus),
    .mode       (mode),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  vec_t       vecs [7];
  logic [7:0] out_pix [$];
  bit         out_last [$];
  int         acc_edge [$];
  int         vld_rise [$];
  int         cyc = 0;
  int         nrdy_lo = 0;
  int         stall_viol = 0;
  int         fd_viol = 0;
  int         done_cnt = 0;
  int         checks = 0;
  int         failures = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Observer: samples on the falling edge, inputs only change just after the rising edge.
  initial begin
    bit         held_v = 1'b0;
    bit         prev_hs = 1'b0;
    bit         prev_mv = 1'b0;
    logic [8:0] held = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        held_v  = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (bus.s_valid && bus.s_ready) acc_edge.push_back(cyc + 1);
        if (bus.m_valid && !prev_mv) vld_rise.push_back(cyc);
        if (!bus.s_ready) nrdy_lo++;
        if (held_v && ({bus.m_valid, bus.m_last, bus.m_pixel} !== {1'b1, held})) stall_viol++;
        if (frame_done !== prev_hs) fd_viol++;
        if (frame_done) done_cnt++;
        if (bus.m_valid && bus.m_ready) begin
          out_pix.push_back(bus.m_pixel);
          out_last.push_back(bus.m_last);
        end
        held_v  = bus.m_valid && !bus.m_ready;
        held    = {bus.m_last, bus.m_pixel};
        prev_hs = bus.m_valid && bus.m_ready && bus.m_last;
      end
      prev_mv = bus.m_valid;
    end
  end

  function automatic logic [95:0] rep(input logic [7:0] x);
    return {12{x}};
  endfunction

  function automatic logic [95:0] put(input logic [95:0] b, input int i, input logic [7:0] x);
    logic [95:0] r;
    r = b;
    r[i*8 +: 8] = x;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic drive_frame(input int v, input bit rnd);
    int n = 0;
    int guard = 0;
    bit acc;
    mode = vecs[v].md;
    while (n < NP && guard < 3000) begin
      bus.s_pixel = vecs[v].pix[n*8 +: 8];
      bus.s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        n++;
        if (n == 6) mode = vecs[v].md_mid;
      end
      guard++;
    end
    bus.s_valid = 1'b0;
    check($sformatf("v%0d_accepts", v), n, NP);
  endtask

  task automatic wait_out(input int target);
    int g = 0;
    while (out_pix.size() < target && g < 2000) begin
      @(posedge clk);
      g++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("out_count", out_pix.size(), target);
  endtask

  task automatic cmp_frames(input int base, input int v0, input int v1, input int v2, input int nf);
    int v, idx, act, lst;
    for (int f = 0; f < nf; f++) begin
      v = (f == 0) ? v0 : ((f == 1) ? v1 : v2);
      for (int k = 0; k < NP; k++) begin
        idx = base + f * NP + k;
        act = (idx < out_pix.size()) ? int'(out_pix[idx]) : -1;
        lst = (idx < out_last.size()) ? int'(out_last[idx]) : -1;
        check($sformatf("f%0d_v%0d_pix%0d", f, v, k), act, int'(vecs[v].exp[k*8 +: 8]));
        check($sformatf("f%0d_v%0d_last%0d", f, v, k), lst, (k == NP - 1) ? 1 : 0);
      end
    end
  endtask

  initial begin
    logic [7:0] inv_in  [12];
    logic [7:0] inv_exp [12];
    int base, d0, act, exp;

    inv_in  = '{8'h00, 8'h5A, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h80};
    inv_exp = '{8'hFF, 8'hA5, 8'h00, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFA, 8'hF9, 8'hF8, 8'hF7, 8'h7F};

    vecs[0] = '{md: 2'b00, md_mid: 2'b01, pix: '0, exp: '0};
    for (int k = 0; k < NP; k++) begin
      vecs[0].pix = put(vecs[0].pix, k, 8'(k));
      vecs[0].exp = put(vecs[0].exp, k, 8'(k));
    end
    vecs[1] = '{md: 2'b01, md_mid: 2'b10, pix: '0, exp: '0};
    for (int k = 0; k < NP; k++) begin
      vecs[1].pix = put(vecs[1].pix, k, inv_in[k]);
      vecs[1].exp = put(vecs[1].exp, k, inv_exp[k]);
    end
    // Laplacian: hot centre clamps high, its right neighbour clamps low
    vecs[2] = '{md: 2'b10, md_mid: 2'b11, pix: put(rep(8'd10), 5, 8'd100),
                exp: put(put(rep(8'd10), 5, 8'd255), 6, 8'd0)};
    vecs[3] = '{md: 2'b10, md_mid: 2'b00, pix: rep(8'd100),
                exp: put(put(rep(8'd100), 5, 8'd0), 6, 8'd0)};
    vecs[4] = '{md: 2'b10, md_mid: 2'b01, pix: put(rep(8'd50), 5, 8'd0),
                exp: put(rep(8'd50), 5, 8'd0)};
    vecs[5] = '{md: 2'b11, md_mid: 2'b00, pix: put(rep(8'd16), 5, 8'd32),
                exp: put(put(rep(8'd16), 5, 8'd20), 6, 8'd18)};
    // Blur truncation: 1020>>4 = 63, 510>>4 = 31
    vecs[6] = '{md: 2'b11, md_mid: 2'b10, pix: put(rep(8'd0), 5, 8'd255),
                exp: put(put(rep(8'd0), 5, 8'd63), 6, 8'd31)};

    bus.s_valid = 1'b0;
    bus.s_pixel = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", int'(bus.m_valid), 0);
    check("rst_m_pixel", int'(bus.m_pixel), 0);
    check("rst_m_last", int'(bus.m_last), 0);
    check("rst_s_ready", int'(bus.s_ready), 1);
    check("rst_frame_done", int'(frame_done), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Unstalled frame: latency, throughput and flush length
    drive_frame(0, 1'b0);
    wait_out(NP);
    cmp_frames(0, 0, 0, 0, 1);
    act = (vld_rise.size() > 0) ? vld_rise[0] : -1;
    exp = (acc_edge.size() > 5) ? acc_edge[5] + 1 : -2;
    check("first_valid_edge", act, exp);
    act = (acc_edge.size() > 11) ? acc_edge[11] - acc_edge[0] : -1;
    check("accept_span", act, NP - 1);
    check("flush_s_ready_low", nrdy_lo, W + 1);
    check("frame_done_count0", done_cnt, 1);

    for (int v = 0; v < 7; v++) begin
      base = out_pix.size();
      d0   = done_cnt;
      drive_frame(v, 1'b0);
      wait_out(base + NP);
      cmp_frames(base, v, v, v, 1);
      check($sformatf("v%0d_frame_done", v), done_cnt, d0 + 1);
    end

    // Gated back-to-back frames with mid-frame mode changes
    rnd_rdy = 1'b1;
    base = out_pix.size();
    d0   = done_cnt;
    drive_frame(5, 1'b1);
    drive_frame(2, 1'b1);
    drive_frame(1, 1'b1);
    wait_out(base + 3 * NP);
    cmp_frames(base, 5, 2, 1, 3);
    check("gated_frame_done", done_cnt, d0 + 3);
    rnd_rdy = 1'b0;
    check("stall_hold_violations", stall_viol, 0);

    // Reset in the middle of a frame
    @(posedge clk);
    #1;
    mode = 2'b00;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.s_pixel = 8'(100 + i);
      @(posedge clk);
      #1;
    end
    rstn = 1'b0;
    #2;
    check("midrst_m_valid", int'(bus.m_valid), 0);
    check("midrst_m_pixel", int'(bus.m_pixel), 0);
    check("midrst_m_last", int'(bus.m_last), 0);
    check("midrst_s_ready", int'(bus.s_ready), 1);
    bus.s_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    base = out_pix.size();
    drive_frame(0, 1'b0);
    wait_out(base + NP);
    cmp_frames(base, 0, 0, 0, 1);

    check("frame_done_timing_violations", fd_viol, 0);
    check("stall_hold_violations_end", stall_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pixel_filter3x3.md
# pixel_filter3x3

Parametrised streaming 3×3 neighbourhood filter for the image-processing datapath, sitting between the pixel producer and the downstream consumer.
- Accepts one raster-order frame of IMG_WIDTH×IMG_HEIGHT pixels over a valid/ready slave port.
- Emits exactly one result per input pixel, in the same raster order, over a valid/ready master port.
- Generalises the single-buffer processor: configurable pixel width and frame size, a full two-stage stall-safe pipeline, an end-of-frame flush, border handling, a blur mode, and frame-level framing outputs.

## Interface
- IMG_WIDTH, 32, pixels per line (≥3)
- IMG_HEIGHT, 32, lines per frame (≥3)
- PIX_W, 8, bits per pixel
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- s_pixel  in  PIX_W  input pixel
- s_valid  in  1  input pixel valid
- s_ready  out  1  block accepts s_pixel this cycle
- m_pixel  out  PIX_W  result pixel
- m_valid  out  1  result valid
- m_ready  in  1  consumer accepts result
- m_last  out  1  high with the last result of a frame
- mode  in  2  00 pass, 01 invert, 10 Laplacian edge, 11 Gaussian blur
- frame_done  out  1  one-cycle pulse on handshake of the m_last beat

## Operation
- States: STREAM and FLUSH.
- Pipeline enable: en = !m_valid || m_ready.
- Handshake:
  - s_ready = (state==STREAM) && en, combinational.
  - An input is accepted when s_valid && s_ready.
- Step: an input accept, or a flush step in FLUSH when en is high. Each step:
  - pushes one sample (s_pixel, or 0 in FLUSH) into the 3×3 window;
  - performs the two-line-buffer shift at column ix: lb0[ix] <= lb1[ix], lb1[ix] <= sample;
  - advances ix/iy with wrap at IMG_WIDTH−1.
- Window centre after step n is stream index c = n−(IMG_WIDTH+1). Stage-1 valid (w_vld) is set when c ≥ 0; it carries the centre coordinates (cx, cy).
- Stage 2 (output register): on en, m_valid <= w_vld and m_pixel <= f(window). When en is high and no step occurs, w_vld clears.
- mode is latched on the accept of pixel (0,0). Changes mid-frame take effect at the next frame.
- Pixel (0,0) is the first accept after reset or after FLUSH completes.
- Last accept of a frame (ix=IMG_WIDTH−1, iy=IMG_HEIGHT−1): go to FLUSH and perform exactly IMG_WIDTH+1 flush steps, then return to STREAM with counters at 0.
- Functions (C = centre pixel, N/S/E/W = orthogonal neighbours, K = corner neighbours, MAX = 2^PIX_W−1):
  - 00: C
  - 01: MAX−C
  - 10: 4C−(N+S+E+W), signed PIX_W+3 bits, clamped to [0, MAX]
  - 11: (ΣK + 2·(N+S+E+W) + 4C) >> 4, PIX_W+4-bit sum, truncating
- Border pixels (cx=0, cx=IMG_WIDTH−1, cy=0 or cy=IMG_HEIGHT−1) output C in modes 10/11. Line buffers are therefore never cleared.
- m_last is set for the result with cx=IMG_WIDTH−1 and cy=IMG_HEIGHT−1.
- frame_done = m_valid && m_ready && m_last, registered one cycle.

## Timing
- Reset values:
  - m_pixel=0, m_valid=0, m_last=0, frame_done=0;
  - state=STREAM, counters=0, w_vld=0, latched mode=00;
  - s_ready=1 after reset because m_valid=0.
- Latency: the result for centre index c is on m_pixel one clock after the edge of the step for index c+IMG_WIDTH+1.
- Throughput: 1 pixel/cycle with m_ready held high.
- FLUSH lasts IMG_WIDTH+1 cycles with s_ready=0 when unstalled.
- While m_valid && !m_ready, m_pixel and m_last hold stable and no step occurs.
- Back-to-back frames: the first accept of the next frame can occur the cycle after the final flush step.
- A reset mid-frame discards all in-flight data. The next accept is pixel (0,0).

## Test plan
- Reset: rstn low mid-stream -> m_valid=0, m_pixel=0, m_last=0, s_ready=1; the next frame (mode 00, 4×3, values 0..11) outputs 0..11 exactly.
- IMG_WIDTH=4, IMG_HEIGHT=3, mode 00, inputs 0..11, m_ready=1 -> first m_valid one cycle after the 6th accept; outputs 0..11 in order; m_last and frame_done on 11; s_ready low for 5 cycles.
- Mode 01, PIX_W=8: inputs 0x00, 0x5A, 0xFF -> 0xFF, 0xA5, 0x00.
- Mode 10, 4×3: centre (1,1)=100 with all others 10 -> 255 (clamped from 360). All pixels 100 -> interior 0. Centre 0 with neighbours 50 -> 0. Border outputs equal their inputs.
- Mode 11, 4×3: all pixels 16 except (1,1)=32 -> (1,1) outputs 20, (2,1) outputs 18.
- Random m_ready/s_valid gating over 3 frames, mode toggled mid-frame -> no lost or duplicated pixels, m_pixel stable while stalled, the new mode applies from the next frame only.
